// File: rtl/btn_event_decoder_pkg.sv
// Shared types and default timing constants for the button event decoder.
// BTN_EVT_REPEAT_EN (see btn_event_decoder.sv) enables auto-repeat in LONG_HELD.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        LOCKOUT        = 3'd0,
        IDLE           = 3'd1,
        PRESSED        = 3'd2,
        LONG_HELD      = 3'd3,
        WAIT_SECOND    = 3'd4,
        SECOND_PRESSED = 3'd5
    } btn_state_t;

    localparam int TICK_N_DEF       = 20;
    localparam int LONG_TICKS_DEF   = 96;
    localparam int DCLICK_TICKS_DEF = 24;
    localparam int REPEAT_TICKS_DEF = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// Button level in, classified event pulses out.
// master: the decoder; slave: whatever drives db and consumes the events.
interface btn_event_decoder_if;

    logic db;
    logic press_p;
    logic release_p;
    logic single_p;
    logic dbl_p;
    logic long_p;
    logic held;

    modport master (
        input  db,
        output press_p, release_p, single_p, dbl_p, long_p, held
    );

    modport slave (
        output db,
        input  press_p, release_p, single_p, dbl_p, long_p, held
    );

endinterface

// File: rtl/btn_event_decoder_tick_gen.sv
// Free-running N-bit wrap counter; tick is high for the one cycle the counter reads zero.
module tick_gen #(
    parameter int N = 20
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        tick  = (cnt_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into press/release/single/double/long events.
// Define BTN_EVT_REPEAT_EN to re-pulse press_p every REPEAT_TICKS while in LONG_HELD.
module btn_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int TICK_N       = TICK_N_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int DCLICK_TICKS = DCLICK_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    btn_event_decoder_if.master  bus
);

    localparam int CW = $clog2(max3(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS) + 1);
    localparam logic [CW-1:0] LONG_C   = CW'(LONG_TICKS);
    localparam logic [CW-1:0] DCLICK_C = CW'(DCLICK_TICKS);

    logic            tick;
    btn_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            repeat_hit;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            single_q, single_d;
    logic            dbl_q, dbl_d;
    logic            long_q, long_d;
    logic            held_q, held_d;

    tick_gen #(.N(TICK_N)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_TICKS);
    assign repeat_hit = (state_q == LONG_HELD) && bus.db && (cnt_q >= REPEAT_C);
`else
    assign repeat_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LOCKOUT;
        else       state_q <= state_d;
    end

    // A db change always takes priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKOUT:        if (!bus.db) state_d = IDLE;
            IDLE:           if (bus.db)  state_d = PRESSED;
            PRESSED: begin
                if (!bus.db)              state_d = WAIT_SECOND;
                else if (cnt_q >= LONG_C) state_d = LONG_HELD;
            end
            LONG_HELD:      if (!bus.db) state_d = IDLE;
            WAIT_SECOND: begin
                if (bus.db)                 state_d = SECOND_PRESSED;
                else if (cnt_q >= DCLICK_C) state_d = IDLE;
            end
            SECOND_PRESSED: if (!bus.db) state_d = IDLE;
            default:        state_d = LOCKOUT;
        endcase
    end

    always_comb begin
        press_d   = ((state_q == IDLE) && bus.db) || ((state_q == WAIT_SECOND) && bus.db) || repeat_hit;
        release_d = !bus.db && ((state_q == PRESSED) || (state_q == LONG_HELD) ||
                                (state_q == SECOND_PRESSED));
        single_d  = (state_q == WAIT_SECOND) && !bus.db && (cnt_q >= DCLICK_C);
        dbl_d     = (state_q == WAIT_SECOND) && bus.db;
        long_d    = (state_q == PRESSED) && bus.db && (cnt_q >= LONG_C);
        held_d    = (state_d == PRESSED) || (state_d == LONG_HELD) || (state_d == SECOND_PRESSED);
    end

    // Tick count restarts on every state change and after each auto-repeat.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || repeat_hit) cnt_d = '0;
        else if (tick && (cnt_q != '1))         cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            dbl_q     <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            single_q  <= single_d;
            dbl_q     <= dbl_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    assign bus.press_p   = press_q;
    assign bus.release_p = release_q;
    assign bus.single_p  = single_q;
    assign bus.dbl_p     = dbl_q;
    assign bus.long_p    = long_q;
    assign bus.held      = held_q;

endmodule
